logic_unit_sched: RTL and testbench



---
 rtl/logic_unit_sched.sv | 140 ++++++++++++++
 tb/tb_logic_unit_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_sched.sv
// Round-robin scheduler that shares one external bitwise logic unit between two requesters.
// Grant 1 cycle after REQ, result 1 cycle later; optional grant counters under LOGIC_SCHED_STATS_EN.
module logic_unit_sched #(
  parameter int DATA_W = 32
`ifdef LOGIC_SCHED_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic [1:0]        OP0,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] B0,
  output logic              GNT0,
  input  logic              REQ1,
  input  logic [1:0]        OP1,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] B1,
  output logic              GNT1,
  output logic [1:0]        LU_OP,
  output logic [DATA_W-1:0] LU_A,
  output logic [DATA_W-1:0] LU_B,
  input  logic [DATA_W-1:0] LU_Y,
  output logic [DATA_W-1:0] RES,
  output logic              RES_VALID,
  output logic              RES_ID,
  output logic              BUSY
`ifdef LOGIC_SCHED_STATS_EN
  , output logic [CNT_W-1:0] STAT0
  , output logic [CNT_W-1:0] STAT1
`endif
);

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_req_any;
  logic                w_win;
  logic                r_last;
  logic                r_win;
  logic                r_gnt0;
  logic                r_gnt1;
  logic                r_busy;
  logic                r_res_vld;
  logic                r_res_id;
  logic [1:0]          r_lu_op;
  logic [DATA_W-1:0]   r_lu_a;
  logic [DATA_W-1:0]   r_lu_b;
  logic [DATA_W-1:0]   r_res;

  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_next    = r_state;
    w_req_any = REQ0 | REQ1;
    w_win     = (REQ0 & REQ1) ? ~r_last : REQ1;
    case (r_state)
      S_IDLE:  if (w_req_any) w_next = S_EXEC;
      S_EXEC:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_last    <= 1'b1;
      r_win     <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_busy    <= 1'b0;
      r_res_vld <= 1'b0;
      r_res_id  <= 1'b0;
      r_lu_op   <= '0;
      r_lu_a    <= '0;
      r_lu_b    <= '0;
      r_res     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_res_vld <= 1'b0;
          if (w_req_any) begin
            r_win   <= w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_busy  <= 1'b1;
            r_lu_op <= w_win ? OP1 : OP0;
            r_lu_a  <= w_win ? A1  : A0;
            r_lu_b  <= w_win ? B1  : B0;
          end
        end
        S_EXEC: begin
          r_res     <= LU_Y;
          r_res_id  <= r_win;
          r_res_vld <= 1'b1;
          r_last    <= r_win;
          r_gnt0    <= 1'b0;
          r_gnt1    <= 1'b0;
          r_busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign GNT0      = r_gnt0;
  assign GNT1      = r_gnt1;
  assign BUSY      = r_busy;
  assign RES_VALID = r_res_vld;
  assign RES_ID    = r_res_id;
  assign RES       = r_res;
  assign LU_OP     = r_lu_op;
  assign LU_A      = r_lu_a;
  assign LU_B      = r_lu_b;

`ifdef LOGIC_SCHED_STATS_EN
  logic [CNT_W-1:0] r_stat0;
  logic [CNT_W-1:0] r_stat1;

  // Counters bump on the same edge that raises the grant and stick at all-ones.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_stat0 <= '0;
      r_stat1 <= '0;
    end else if (r_state == S_IDLE && w_req_any) begin
      if (!w_win && !(&r_stat0)) r_stat0 <= r_stat0 + CNT_W'(1);
      if ( w_win && !(&r_stat1)) r_stat1 <= r_stat1 + CNT_W'(1);
    end
  end

  assign STAT0 = r_stat0;
  assign STAT1 = r_stat1;
`endif

endmodule

// File: tb/tb_logic_unit_sched.sv
// Directed plus randomized bench for logic_unit_sched against a transaction-level reference model.
module tb_logic_unit_sched;
  localparam int DATA_W = 32;
`ifdef LOGIC_SCHED_STATS_EN
  localparam int CNT_W = 2;
`endif

  logic              CLK = 1'b0;
  logic              RST, REQ0, REQ1;
  logic [1:0]        OP0, OP1;
  logic [DATA_W-1:0] A0, B0, A1, B1;
  logic              GNT0, GNT1, RES_VALID, RES_ID, BUSY;
  logic [1:0]        LU_OP;
  logic [DATA_W-1:0] LU_A, LU_B, LU_Y, RES;
`ifdef LOGIC_SCHED_STATS_EN
  logic [CNT_W-1:0]  STAT0, STAT1;
`endif

  always #5 CLK = ~CLK;

  function automatic logic [DATA_W-1:0] lu_fn(input logic [1:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a | b);
      default: return ~a;
    endcase
  endfunction

  // The shared gate bank lives outside the scheduler.
  assign LU_Y = lu_fn(LU_OP, LU_A, LU_B);

  logic_unit_sched #(
    .DATA_W(DATA_W)
`ifdef LOGIC_SCHED_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .OP0(OP0), .A0(A0), .B0(B0), .GNT0(GNT0),
    .REQ1(REQ1), .OP1(OP1), .A1(A1), .B1(B1), .GNT1(GNT1),
    .LU_OP(LU_OP), .LU_A(LU_A), .LU_B(LU_B), .LU_Y(LU_Y),
    .RES(RES), .RES_VALID(RES_VALID), .RES_ID(RES_ID), .BUSY(BUSY)
`ifdef LOGIC_SCHED_STATS_EN
    , .STAT0(STAT0), .STAT1(STAT1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one pending transaction plus the observable outputs.
  bit              m_pending;
  int              m_owner;
  int              m_last;
  logic [1:0]      m_op;
  logic [31:0]     m_a, m_b, m_res;
  bit              m_gnt0, m_gnt1, m_busy, m_vld, m_id;
  int              m_s0, m_s1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit r0, input bit r1);
    int w;
    int smax;
    smax = 65535;
`ifdef LOGIC_SCHED_STATS_EN
    smax = (1 << CNT_W) - 1;
`endif
    if (!rst) begin
      m_pending = 0; m_owner = 0; m_last = 1;
      m_op = 0; m_a = 0; m_b = 0; m_res = 0;
      m_gnt0 = 0; m_gnt1 = 0; m_busy = 0; m_vld = 0; m_id = 0;
      m_s0 = 0; m_s1 = 0;
    end else if (m_pending) begin
      m_res = lu_fn(m_op, m_a, m_b);
      m_id = (m_owner == 1);
      m_vld = 1; m_last = m_owner; m_pending = 0;
      m_gnt0 = 0; m_gnt1 = 0; m_busy = 0;
    end else begin
      m_vld = 0;
      if (r0 || r1) begin
        if (r0 && r1) w = 1 - m_last;
        else          w = r1 ? 1 : 0;
        m_owner = w; m_pending = 1; m_busy = 1;
        m_gnt0 = (w == 0); m_gnt1 = (w == 1);
        m_op = w ? OP1 : OP0;
        m_a  = w ? A1 : A0;
        m_b  = w ? B1 : B0;
        if (w == 0) m_s0 = (m_s0 < smax) ? m_s0 + 1 : smax;
        else        m_s1 = (m_s1 < smax) ? m_s1 + 1 : smax;
      end
    end
  endtask

  task automatic cycle();
    bit rst, r0, r1;
    rst = RST; r0 = REQ0; r1 = REQ1;
    @(posedge CLK);
    model_edge(rst, r0, r1);
    #1;
    chk("gnt0", 32'(GNT0), 32'(m_gnt0));
    chk("gnt1", 32'(GNT1), 32'(m_gnt1));
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("res_valid", 32'(RES_VALID), 32'(m_vld));
    chk("res_id", 32'(RES_ID), 32'(m_id));
    chk("res", RES, m_res);
    chk("lu_op", 32'(LU_OP), 32'(m_op));
    chk("lu_a", LU_A, m_a);
    chk("lu_b", LU_B, m_b);
`ifdef LOGIC_SCHED_STATS_EN
    chk("stat0", 32'(STAT0), 32'(m_s0));
    chk("stat1", 32'(STAT1), 32'(m_s1));
`endif
  endtask

  initial begin
    RST = 1'b0; REQ0 = 1'b1; REQ1 = 1'b1;
    OP0 = 2'b00; OP1 = 2'b00;
    A0 = 32'h0a17b980; B0 = 32'h11af6077; A1 = 32'h0; B1 = 32'h0;
    #1;

    // Reset held with both requesting: nothing may be granted.
    cycle(); cycle();
    chk("rst_gnt0", 32'(GNT0), 32'h0);
    chk("rst_res", RES, 32'h0);
    RST = 1'b1;
    cycle();
    chk("first_tie_r0", 32'(GNT0), 32'h1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    cycle(); cycle();

    // INV A with zero operand; B still visible on LU_B.
    REQ1 = 1'b1; OP1 = 2'b11; A1 = 32'h0; B1 = 32'hffffffff;
    cycle();
    chk("inv_lu_b", LU_B, 32'hffffffff);
    REQ1 = 1'b0;
    cycle();
    chk("inv_res", RES, 32'hffffffff);
    chk("inv_id", 32'(RES_ID), 32'h1);
    cycle();

    // Round-robin with both held.
    REQ0 = 1'b1; OP0 = 2'b01; REQ1 = 1'b1; OP1 = 2'b10;
    A1 = 32'h0a17b980; B1 = 32'h11af6077;
    cycle(); cycle();
    chk("rr_res0", RES, 32'h1bbff9f7);
    chk("rr_id0", 32'(RES_ID), 32'h0);
    cycle(); cycle();
    chk("rr_res1", RES, 32'he4400608);
    chk("rr_id1", 32'(RES_ID), 32'h1);
    cycle(); cycle();
    chk("rr_res2", RES, 32'h1bbff9f7);
    REQ0 = 1'b0; REQ1 = 1'b0;
    cycle();

    // Single AND request.
    REQ0 = 1'b1; OP0 = 2'b00;
    cycle();
    chk("single_gnt0", 32'(GNT0), 32'h1);
    REQ0 = 1'b0;
    cycle();
    chk("single_res", RES, 32'h00072000);
    chk("single_vld", 32'(RES_VALID), 32'h1);
    chk("single_busy", 32'(BUSY), 32'h0);
    cycle();
    chk("single_vld_end", 32'(RES_VALID), 32'h0);

    // Reset on the EXEC edge of an R1 op.
    REQ1 = 1'b1; OP1 = 2'b01;
    cycle();
    REQ1 = 1'b0; RST = 1'b0;
    cycle();
    chk("midrst_vld", 32'(RES_VALID), 32'h0);
    chk("midrst_res", RES, 32'h0);
    RST = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
    cycle();
    chk("midrst_tie_r0", 32'(GNT0), 32'h1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    cycle(); cycle();

`ifdef LOGIC_SCHED_STATS_EN
    RST = 1'b0; cycle(); RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      REQ0 = 1'b1;
      cycle();
      chk("stat0_sat", 32'(STAT0), (k < 3) ? 32'(k + 1) : 32'd3);
      chk("stat1_zero", 32'(STAT1), 32'h0);
      REQ0 = 1'b0;
      cycle();
    end
`endif

    // Randomized requesters obeying the hold/drop protocol, with sporadic resets.
    for (int n = 0; n < 600; n++) begin
      RST = ($urandom_range(0, 63) != 0);
      if (!REQ0 && $urandom_range(0, 2) == 0) begin
        REQ0 = 1'b1; OP0 = 2'($urandom); A0 = $urandom; B0 = $urandom;
      end
      if (!REQ1 && $urandom_range(0, 2) == 0) begin
        REQ1 = 1'b1; OP1 = 2'($urandom); A1 = $urandom; B1 = $urandom;
      end
      cycle();
      if (GNT0) REQ0 = 1'b0;
      if (GNT1) REQ1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
